rtmc_pwm_bank: RTL and testbench
================================

Name: rtmc_pwm_bank

Overview:
- Parametrised N-pair complementary PWM generator for the rtmc motor-control outputs.
- Generalises the fixed 4-bit `mc`/`mc_oe` output stage to `N_PAIR` high/low-side pairs.
- Adds edge- or center-aligned counting, double-buffered period/duty, per-block deadtime insertion and a latched fault shutdown.
- Configured through a simple register write/read port driven by the SPI core.

Parameters:
- N_PAIR, 2: number of complementary output pairs; mc width = 2*N_PAIR.
- CNT_W, 12: width of the counter, PERIOD, DUTY and cfg data.
- DT_W, 4: width of the DEADTIME register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  register write strobe, one cycle
- cfg_addr  in  AW  register address; AW = $clog2(N_PAIR+3)
- cfg_wdata  in  CNT_W  write data
- cfg_rdata  out  CNT_W  combinational read of the addressed programmed register
- fault  in  1  synchronous fault request, active high
- sync_out  out  1  one-cycle pulse at each period start
- mc  out  2*N_PAIR  pair i: mc[2i] = high side, mc[2i+1] = low side
- mc_oe  out  2*N_PAIR  output enables

Behaviour:
- Register map:
  - 0 CTRL: bit0 enable, bit1 center mode, bit2 fault_clr (write-only, self-clearing); read bit3 = fault_latched.
  - 1 PERIOD.
  - 2 DEADTIME (low DT_W bits).
  - 3+i DUTY[i].
  - Undefined addresses: writes ignored, reads return 0.
- Reset: all registers, counter, active (shadow) copies and fault_latched = 0; mc = 0, mc_oe = 0, sync_out = 0.
- Disabled (enable = 0): cnt held at 0, mc = 0, mc_oe = 0.
- Enable 0->1: active PERIOD/DUTY/DEADTIME loaded from the programmed values that cycle; cnt = 0; sync_out pulses on the following cycle.
- Edge mode:
  - cnt sequence 0,1,...,PERIOD,0,...; period = PERIOD+1 cycles.
  - Period start = cnt wrapping to 0.
- Center mode:
  - cnt counts up 0..PERIOD, then down PERIOD-1..1, then 0; period = 2*PERIOD cycles.
  - PERIOD = 0 behaves as a constant cnt = 0.
- Shadow load: at every period start the active copies take the programmed values as they stood before any same-cycle cfg write. A write landing in the boundary cycle takes effect one period later.
- Reference: ref_i = (cnt < DUTY_act[i]), unsigned compare.
  - DUTY = 0 gives 0% high.
  - DUTY > PERIOD gives 100% high.
- Deadtime, per pair, with DT = DEADTIME_act:
  - High side asserts only once ref_i has been 1 for DT consecutive cycles.
  - Low side asserts only once ref_i has been 0 for DT consecutive cycles.
  - Both sides deassert immediately when ref_i changes.
  - DT = 0 gives exact complements.
  - mc[2i] & mc[2i+1] is never 1.
- Latency: mc and sync_out are registered, one cycle after the cnt value they derive from.
- mc_oe = all ones while enabled (including during fault).
- Fault:
  - fault = 1 sets fault_latched on the next edge; while latched, mc = 0, and cnt keeps running.
  - Writing CTRL with fault_clr = 1 clears the latch only if fault = 0 in that cycle; if fault is still 1, fault wins and the latch stays set.
- Reset asserted mid-operation: outputs go to their reset values immediately (asynchronously).

Test Plan:
- Edge, basic PWM: N_PAIR = 2, CNT_W = 8, PERIOD = 9, DUTY0 = 3, DT = 0, enable -> mc[0] high 3 of every 10 cycles, mc[1] high the other 7; sync_out pulses every 10 cycles.
- Edge, deadtime: same as above with DT = 2 -> per 10-cycle period, mc[0] high 1 cycle, mc[1] high 5 cycles, two 2-cycle gaps with both low; both sides never high together.
- Center mode: PERIOD = 4, DUTY0 = 2 -> cnt sequence 0,1,2,3,4,3,2,1; mc[0] high 3 of 8 cycles; sync_out every 8 cycles.
- Double buffering: change DUTY0 3 -> 6 mid-period -> old duty completes that period, new duty from the next sync_out. A write in the boundary cycle appears one period later.
- Limits: DUTY1 = 0 -> mc[2] = 0 and mc[3] = 1 constantly; DUTY1 = 255 with PERIOD = 9 -> mc[2] = 1 and mc[3] = 0.
- Fault and reset:
  - fault = 1 for 1 cycle -> mc = 0 from the next cycle and CTRL read bit3 = 1.
  - fault_clr written while fault = 1 -> latch stays set; written with fault = 0 -> PWM resumes.
  - rst_n pulsed low mid-period -> mc = 0, mc_oe = 0 and all registers read 0.

Source files
------------

// File: rtl/rtmc_pwm_bank.sv
// N-pair complementary PWM generator: edge/center counter, double-buffered
// period/duty/deadtime, per-pair deadtime insertion and latched fault shutdown.
module rtmc_pwm_bank #(
  parameter  int N_PAIR = 2,
  parameter  int CNT_W  = 12,
  parameter  int DT_W   = 4,
  localparam int AW     = $clog2(N_PAIR + 3),
  localparam int MW     = 2 * N_PAIR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic [CNT_W-1:0] cfg_rdata,
  input  logic             fault,
  output logic             sync_out,
  output logic [MW-1:0]    mc,
  output logic [MW-1:0]    mc_oe
);
  localparam int RW = DT_W + 1;

  logic             en_q, center_q, fault_latched_q;
  logic [CNT_W-1:0] period_q, period_act_q;
  logic [DT_W-1:0]  dt_q, dt_act_q;
  logic [CNT_W-1:0] duty_q     [N_PAIR];
  logic [CNT_W-1:0] duty_act_q [N_PAIR];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dn_q, dn_d, wrap;
  logic [N_PAIR-1:0] ref_c, ref_prev_q;
  logic [RW-1:0]    run_q [N_PAIR];
  logic [RW-1:0]    run_d [N_PAIR];
  logic [MW-1:0]    mc_q, mc_d;
  logic             sync_q;
  logic             ctrl_wr, clr_wr;

  assign ctrl_wr = cfg_we && (cfg_addr == AW'(0));
  assign clr_wr  = ctrl_wr && cfg_wdata[2];

  // wrap marks the edge into a period start; while disabled the shadows track
  // the programmed values so the enabling edge loads them.
  always_comb begin
    cnt_d = '0;
    dn_d  = 1'b0;
    wrap  = 1'b1;
    if (en_q) begin
      if (!center_q) begin
        if (cnt_q != period_act_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          wrap  = 1'b0;
        end
      end else if (period_act_q != '0) begin
        if (!dn_q && (cnt_q < period_act_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
          wrap  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q != CNT_W'(1)) begin
            dn_d = 1'b1;
            wrap = 1'b0;
          end
        end
      end
    end
  end

  // run_d counts how many consecutive cycles (including this one) ref has held.
  always_comb begin
    mc_d  = '0;
    ref_c = '0;
    for (int i = 0; i < N_PAIR; i++) begin
      ref_c[i] = (cnt_q < duty_act_q[i]);
      run_d[i] = run_q[i];
      if (!en_q) run_d[i] = '0;
      else if (ref_c[i] != ref_prev_q[i]) run_d[i] = RW'(1);
      else if (run_q[i] != '1) run_d[i] = run_q[i] + RW'(1);
      mc_d[2*i]   = ref_c[i] && (run_d[i] > {1'b0, dt_act_q});
      mc_d[2*i+1] = !ref_c[i] && (run_d[i] > {1'b0, dt_act_q});
    end
    if (!en_q || fault || fault_latched_q) mc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q            <= 1'b0;
      center_q        <= 1'b0;
      fault_latched_q <= 1'b0;
      period_q        <= '0;
      period_act_q    <= '0;
      dt_q            <= '0;
      dt_act_q        <= '0;
      cnt_q           <= '0;
      dn_q            <= 1'b0;
      ref_prev_q      <= '0;
      mc_q            <= '0;
      sync_q          <= 1'b0;
      for (int i = 0; i < N_PAIR; i++) begin
        duty_q[i]     <= '0;
        duty_act_q[i] <= '0;
        run_q[i]      <= '0;
      end
    end else begin
      if (ctrl_wr) begin
        en_q     <= cfg_wdata[0];
        center_q <= cfg_wdata[1];
      end
      if (cfg_we && (cfg_addr == AW'(1))) period_q <= cfg_wdata;
      if (cfg_we && (cfg_addr == AW'(2))) dt_q <= cfg_wdata[DT_W-1:0];
      // A fault in the same cycle as a clear keeps the latch set.
      fault_latched_q <= fault | (fault_latched_q & ~clr_wr);
      if (wrap) begin
        period_act_q <= period_q;
        dt_act_q     <= dt_q;
      end
      cnt_q      <= cnt_d;
      dn_q       <= dn_d;
      ref_prev_q <= en_q ? ref_c : '0;
      mc_q       <= mc_d;
      sync_q     <= en_q && (cnt_q == '0);
      for (int i = 0; i < N_PAIR; i++) begin
        if (cfg_we && (cfg_addr == AW'(i + 3))) duty_q[i] <= cfg_wdata;
        if (wrap) duty_act_q[i] <= duty_q[i];
        run_q[i] <= run_d[i];
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr == AW'(0)) cfg_rdata[3:0] = {fault_latched_q, 1'b0, center_q, en_q};
    else if (cfg_addr == AW'(1)) cfg_rdata = period_q;
    else if (cfg_addr == AW'(2)) cfg_rdata[DT_W-1:0] = dt_q;
    for (int i = 0; i < N_PAIR; i++) begin
      if (cfg_addr == AW'(i + 3)) cfg_rdata = duty_q[i];
    end
  end

  assign mc       = mc_q & {MW{en_q}};
  assign mc_oe    = {MW{en_q}};
  assign sync_out = sync_q;

endmodule

// File: tb/tb_rtmc_pwm_bank.sv
// Bench for rtmc_pwm_bank: a period/phase reference model feeds an expected
// queue each cycle; a monitor pops and compares the DUT outputs at negedge.
module tb_rtmc_pwm_bank;
  localparam int NP = 2;
  localparam int CW = 8;
  localparam int DW = 4;
  localparam int AW = 3;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic          fault = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_wdata = '0;
  logic [CW-1:0] cfg_rdata;
  logic          sync_out;
  logic [MW-1:0] mc, mc_oe;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];

  // Reference model: programmed regs, active copies, phase within the period
  // and a history of reference levels since enable.
  bit m_en, m_center, m_lat;
  int m_per, m_dt, m_duty[NP];
  int a_per, a_dt, a_duty[NP];
  int m_phase;
  logic [NP-1:0] hist_q[$];

  int w_h[MW];
  int w_s;

  rtmc_pwm_bank #(.N_PAIR(NP), .CNT_W(CW), .DT_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .fault(fault),
    .sync_out(sync_out), .mc(mc), .mc_oe(mc_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int plen();
    if (m_center) return (a_per == 0) ? 1 : 2 * a_per;
    return a_per + 1;
  endfunction

  function automatic int cur_cnt();
    if (m_center && (m_phase > a_per)) return 2 * a_per - m_phase;
    return m_phase;
  endfunction

  function automatic int model_rd(input int a);
    case (a)
      0: return (m_lat ? 8 : 0) | (m_center ? 2 : 0) | (m_en ? 1 : 0);
      1: return m_per;
      2: return m_dt;
      3: return m_duty[0];
      4: return m_duty[1];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_center = 0; m_lat = 0;
    m_per = 0; m_dt = 0; a_per = 0; a_dt = 0; m_phase = 0;
    for (int i = 0; i < NP; i++) begin
      m_duty[i] = 0;
      a_duty[i] = 0;
    end
    hist_q.delete();
  endtask

  task automatic load_active();
    a_per = m_per;
    a_dt = m_dt;
    for (int i = 0; i < NP; i++) a_duty[i] = m_duty[i];
  endtask

  task automatic model_step();
    int c;
    int sz;
    logic [NP-1:0] r;
    logic [MW-1:0] n_mc;
    bit n_sync, clr, hi_ok, lo_ok;
    c = cur_cnt();
    n_mc = '0;
    r = '0;
    if (m_en) begin
      for (int i = 0; i < NP; i++) r[i] = (c < a_duty[i]);
      hist_q.push_back(r);
      if (hist_q.size() > 40) void'(hist_q.pop_front());
      sz = hist_q.size();
      for (int i = 0; i < NP; i++) begin
        hi_ok = (sz > a_dt);
        lo_ok = hi_ok;
        for (int j = 0; (j <= a_dt) && (j < sz); j++) begin
          if (hist_q[sz-1-j][i]) lo_ok = 0;
          else hi_ok = 0;
        end
        n_mc[2*i] = hi_ok;
        n_mc[2*i+1] = lo_ok;
      end
      if (fault || m_lat) n_mc = '0;
    end else begin
      hist_q.delete();
    end
    n_sync = m_en && (c == 0);
    if (m_en) begin
      m_phase++;
      if (m_phase >= plen()) begin
        m_phase = 0;
        load_active();
      end
    end else begin
      m_phase = 0;
      load_active();
    end
    clr = cfg_we && (cfg_addr == 0) && cfg_wdata[2];
    m_lat = fault || (m_lat && !clr);
    if (cfg_we) begin
      case (cfg_addr)
        3'd0: begin m_en = cfg_wdata[0]; m_center = cfg_wdata[1]; end
        3'd1: m_per = cfg_wdata;
        3'd2: m_dt = cfg_wdata[3:0];
        3'd3: m_duty[0] = cfg_wdata;
        3'd4: m_duty[1] = cfg_wdata;
        default: ;
      endcase
    end
    exp_q.push_back({n_sync, {MW{m_en}}, n_mc & {MW{m_en}}});
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pwm_out", {sync_out, mc_oe, mc}, e);
        end
        check("no_overlap", (mc[0] & mc[1]) | (mc[2] & mc[3]), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_wdata = CW'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic chk_rd(input int a, input string nm);
    cfg_addr = AW'(a);
    @(negedge clk);
    check(nm, cfg_rdata, model_rd(a));
    step();
  endtask

  task automatic win(input int n);
    for (int i = 0; i < MW; i++) w_h[i] = 0;
    w_s = 0;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < MW; i++) w_h[i] += int'(mc[i]);
      w_s += int'(sync_out);
    end
    step();
  endtask

  task automatic rst_checks();
    check("rst_mc", mc, 0);
    check("rst_mc_oe", mc_oe, 0);
    check("rst_sync", sync_out, 0);
    for (int a = 0; a < 8; a++) begin
      cfg_addr = AW'(a);
      #1;
      check("rst_rd", cfg_rdata, 0);
    end
  endtask

  task automatic wait_phase(input int ph, input string nm);
    bit found;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      if (m_phase == ph) begin
        found = 1;
        break;
      end
      step();
    end
    check(nm, found, 1);
  endtask

  function automatic int rnd_duty();
    if ($urandom_range(0, 9) == 0) return 255;
    return $urandom_range(0, 22);
  endfunction

  initial begin
    int r;
    bit cm;
    repeat (3) @(posedge clk);
    #2;
    rst_checks();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();

    // Edge mode, DT = 0
    wr(1, 9); wr(3, 3); wr(4, 5); wr(2, 0); wr(0, 1);
    idle(15);
    win(10);
    check("edge_h0", w_h[0], 3); check("edge_l0", w_h[1], 7);
    check("edge_h1", w_h[2], 5); check("edge_sync", w_s, 1);
    chk_rd(0, "rd_ctrl"); chk_rd(1, "rd_period"); chk_rd(3, "rd_duty0");

    // Edge mode, DT = 2
    wr(2, 2);
    idle(15);
    win(10);
    check("dt_h0", w_h[0], 1); check("dt_l0", w_h[1], 5);
    check("dt_h1", w_h[2], 3); check("dt_l1", w_h[3], 3); check("dt_sync", w_s, 1);

    // Double buffering: mid-period write, then boundary-cycle write
    wait_phase(4, "mid_found");
    wr(3, 6);
    idle(25);
    win(10);
    check("dbuf_new", w_h[0], 4);
    wait_phase(9, "boundary_found");
    wr(3, 3);
    win(10);
    check("dbuf_boundary_old", w_h[0], 4);
    win(10);
    check("dbuf_boundary_new", w_h[0], 1);

    // Duty limits on pair 1
    wr(4, 0);
    idle(22);
    win(10);
    check("lim0_h1", w_h[2], 0); check("lim0_l1", w_h[3], 10);
    wr(4, 255);
    idle(22);
    win(10);
    check("lim255_h1", w_h[2], 10); check("lim255_l1", w_h[3], 0);

    // Center mode
    wr(0, 0); wr(2, 0); wr(1, 4); wr(3, 2); wr(0, 3);
    idle(10);
    win(8);
    check("ctr_h0", w_h[0], 3); check("ctr_l0", w_h[1], 5); check("ctr_sync", w_s, 1);

    // Fault latch and clear
    fault = 1'b1;
    step();
    fault = 1'b0;
    cfg_addr = AW'(0);
    @(negedge clk);
    check("fault_bit", cfg_rdata[3], 1);
    check("fault_mc", mc, 0);
    step();
    win(8);
    check("fault_h0", w_h[0], 0); check("fault_l0", w_h[1], 0); check("fault_sync", w_s, 1);
    fault = 1'b1;
    cfg_we = 1'b1; cfg_addr = AW'(0); cfg_wdata = CW'(7);
    step();
    cfg_we = 1'b0; fault = 1'b0;
    @(negedge clk);
    check("clr_vs_fault", cfg_rdata[3], 1);
    step();
    wr(0, 7);
    cfg_addr = AW'(0);
    @(negedge clk);
    check("clr_ok", cfg_rdata[3], 0);
    step();
    idle(8);
    win(8);
    check("resume_h0", w_h[0], 3); check("resume_l0", w_h[1], 5);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      if (r < 8) wr(3 + $urandom_range(0, 1), rnd_duty());
      else if (r < 10) wr(1, $urandom_range(0, 20));
      else if (r < 12) wr(2, $urandom_range(0, 5));
      else if (r < 14) begin
        fault = 1'b1;
        step();
        fault = 1'b0;
      end
      else if (r < 17) wr(0, 5 | (m_center ? 2 : 0));
      else if (r < 20) chk_rd($urandom_range(0, 7), "rand_rd");
      else if (r == 20) begin
        cm = 1'($urandom_range(0, 1));
        wr(0, cm ? 2 : 0);
        wr(0, cm ? 3 : 1);
      end
      else step();
    end

    // Reset mid-period
    wr(0, 0); wr(1, 9); wr(2, 0); wr(3, 3); wr(0, 1);
    idle(14);
    #2 rst_n = 1'b0;
    #1;
    rst_checks();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    wr(1, 9); wr(3, 3); wr(0, 1);
    idle(12);
    win(10);
    check("post_rst_h0", w_h[0], 3); check("post_rst_sync", w_s, 1);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
